// File: rtl/dongho_display.sv
// ---------------------------------------------------------------------------
// dongho_display
//
// Display stage for the calendar counter. Once per display frame the six
// calendar fields and the view mode are snapshotted, each field is converted
// to BCD by a sequential shift-add-3 (double-dabble) engine, and all eight
// digits plus their decimal points are committed to the display buffer on a
// single edge. A scan counter walks the active-low digit enables across the
// buffer, holding each digit for SCAN_DIV clocks.
//
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   sec   - seconds (6 bits)          min  - minutes (6 bits)
//   hour  - hours (5 bits)            day  - day of month (5 bits)
//   mont  - month (4 bits)            year - year (13 bits)
//   mode  - 0 = time view, 1 = date view
//   an    - digit enables, active-low one-hot, an[0] = rightmost digit
//   seg   - segments {g,f,e,d,c,b,a}, active-low
//   dp    - decimal point, active-low
//   busy  - high while a conversion (LOAD/SHIFT/COMMIT) is in progress
// ---------------------------------------------------------------------------
module dongho_display #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  sec,
    input  logic [5:0]  min,
    input  logic [4:0]  hour,
    input  logic [4:0]  day,
    input  logic [3:0]  mont,
    input  logic [12:0] year,
    input  logic        mode,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam logic [3:0] BLANK = 4'hF;

    // Scan counter and digit index
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    dig_q, dig_d;
    logic          frame_start;

    // Converter state
    logic [1:0]  state_q, state_d;
    logic [2:0]  field_q, field_d;
    logic [3:0]  bits_q, bits_d;
    logic [12:0] sr_q, sr_d;
    logic [14:0] bcd_q, bcd_d;
    logic [11:0] bcd_adj;
    logic [15:0] bcd_shift;
    logic [12:0] ld_val;
    logic [3:0]  ld_width;

    // Snapshot of the inputs taken at frame start
    logic [5:0]  sec_s_q, sec_s_d;
    logic [5:0]  min_s_q, min_s_d;
    logic [4:0]  hour_s_q, hour_s_d;
    logic [4:0]  day_s_q, day_s_d;
    logic [3:0]  mont_s_q, mont_s_d;
    logic [12:0] year_s_q, year_s_d;
    logic        mode_s_q, mode_s_d;

    // Per-field BCD results, held until COMMIT
    logic [7:0]  sec_r_q, sec_r_d;
    logic [7:0]  min_r_q, min_r_d;
    logic [7:0]  hour_r_q, hour_r_d;
    logic [7:0]  day_r_q, day_r_d;
    logic [7:0]  mont_r_q, mont_r_d;
    logic [15:0] year_r_q, year_r_d;

    // Display buffer: one BCD nibble per digit plus a lit flag per DP
    logic [7:0][3:0] buf_q, buf_d;
    logic [7:0]      dpb_q, dpb_d;

    // Registered outputs
    logic [7:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;

    // Active-low segment pattern for one BCD nibble; non-BCD codes blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Scan counter: cnt runs 0..SCAN_DIV-1, dig advances on the last count.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        dig_d = dig_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            dig_d = dig_q + 3'd1;
        end
    end

    assign frame_start = (cnt_q == '0) && (dig_q == 3'd0);

    // Field selection for LOAD. Narrow fields are left-aligned in the shift
    // register so the MSB always leaves from bit 12.
    always_comb begin
        ld_val   = year_s_q;
        ld_width = 4'd13;
        case (field_q)
            3'd0: begin ld_val = {sec_s_q,  7'b0}; ld_width = 4'd6; end
            3'd1: begin ld_val = {min_s_q,  7'b0}; ld_width = 4'd6; end
            3'd2: begin ld_val = {hour_s_q, 8'b0}; ld_width = 4'd5; end
            3'd3: begin ld_val = {day_s_q,  8'b0}; ld_width = 4'd5; end
            3'd4: begin ld_val = {mont_s_q, 9'b0}; ld_width = 4'd4; end
            default: begin ld_val = year_s_q; ld_width = 4'd13; end
        endcase
    end

    // Add-3 correction on the low three BCD nibbles. The thousands nibble
    // never exceeds 4 before its final shift (inputs are below 8192), so it
    // needs no correction and only three bits of it are kept between shifts.
    always_comb begin
        bcd_adj = bcd_q[11:0];
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_shift = {bcd_q[14:12], bcd_adj, sr_q[12]};

    // Converter FSM: snapshot at frame start, then LOAD/SHIFT per field in
    // order sec, min, hour, day, mont, year, then one COMMIT cycle.
    always_comb begin
        state_d  = state_q;
        field_d  = field_q;
        bits_d   = bits_q;
        sr_d     = sr_q;
        bcd_d    = bcd_q;
        sec_s_d  = sec_s_q;
        min_s_d  = min_s_q;
        hour_s_d = hour_s_q;
        day_s_d  = day_s_q;
        mont_s_d = mont_s_q;
        year_s_d = year_s_q;
        mode_s_d = mode_s_q;
        sec_r_d  = sec_r_q;
        min_r_d  = min_r_q;
        hour_r_d = hour_r_q;
        day_r_d  = day_r_q;
        mont_r_d = mont_r_q;
        year_r_d = year_r_q;
        buf_d    = buf_q;
        dpb_d    = dpb_q;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    sec_s_d  = sec;
                    min_s_d  = min;
                    hour_s_d = hour;
                    day_s_d  = day;
                    mont_s_d = mont;
                    year_s_d = year;
                    mode_s_d = mode;
                    field_d  = 3'd0;
                    state_d  = S_LOAD;
                end
            end

            S_LOAD: begin
                bcd_d   = '0;
                sr_d    = ld_val;
                bits_d  = ld_width;
                state_d = S_SHIFT;
            end

            S_SHIFT: begin
                bcd_d  = bcd_shift[14:0];
                sr_d   = {sr_q[11:0], 1'b0};
                bits_d = bits_q - 4'd1;
                if (bits_q == 4'd1) begin
                    case (field_q)
                        3'd0:    sec_r_d  = bcd_shift[7:0];
                        3'd1:    min_r_d  = bcd_shift[7:0];
                        3'd2:    hour_r_d = bcd_shift[7:0];
                        3'd3:    day_r_d  = bcd_shift[7:0];
                        3'd4:    mont_r_d = bcd_shift[7:0];
                        default: year_r_d = bcd_shift;
                    endcase
                    if (field_q == 3'd5) begin
                        state_d = S_COMMIT;
                    end else begin
                        field_d = field_q + 3'd1;
                        state_d = S_LOAD;
                    end
                end
            end

            S_COMMIT: begin
                // All digits and DPs replace the buffer on this one edge.
                if (mode_s_q == 1'b0) begin
                    buf_d[7] = BLANK;
                    buf_d[6] = BLANK;
                    buf_d[5] = hour_r_q[7:4];
                    buf_d[4] = hour_r_q[3:0];
                    buf_d[3] = min_r_q[7:4];
                    buf_d[2] = min_r_q[3:0];
                    buf_d[1] = sec_r_q[7:4];
                    buf_d[0] = sec_r_q[3:0];
                    dpb_d    = 8'b0001_0100;
                end else begin
                    buf_d[7] = day_r_q[7:4];
                    buf_d[6] = day_r_q[3:0];
                    buf_d[5] = mont_r_q[7:4];
                    buf_d[4] = mont_r_q[3:0];
                    buf_d[3] = year_r_q[15:12];
                    buf_d[2] = year_r_q[11:8];
                    buf_d[1] = year_r_q[7:4];
                    buf_d[0] = year_r_q[3:0];
                    dpb_d    = 8'b0101_0000;
                end
                field_d = 3'd0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Output stage: registered from the current digit index and the buffer,
    // so outputs follow dig or a COMMIT by one clock.
    always_comb begin
        an_d  = ~(8'd1 << dig_q);
        seg_d = seg_decode(buf_q[dig_q]);
        dp_d  = ~dpb_q[dig_q];
    end

    // State registers; reset blanks the buffer and aborts any conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            dig_q    <= 3'd0;
            state_q  <= S_IDLE;
            field_q  <= 3'd0;
            bits_q   <= 4'd0;
            sr_q     <= '0;
            bcd_q    <= '0;
            sec_s_q  <= '0;
            min_s_q  <= '0;
            hour_s_q <= '0;
            day_s_q  <= '0;
            mont_s_q <= '0;
            year_s_q <= '0;
            mode_s_q <= 1'b0;
            sec_r_q  <= '0;
            min_r_q  <= '0;
            hour_r_q <= '0;
            day_r_q  <= '0;
            mont_r_q <= '0;
            year_r_q <= '0;
            buf_q    <= {8{BLANK}};
            dpb_q    <= 8'h00;
            an_q     <= 8'hFF;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            state_q  <= state_d;
            field_q  <= field_d;
            bits_q   <= bits_d;
            sr_q     <= sr_d;
            bcd_q    <= bcd_d;
            sec_s_q  <= sec_s_d;
            min_s_q  <= min_s_d;
            hour_s_q <= hour_s_d;
            day_s_q  <= day_s_d;
            mont_s_q <= mont_s_d;
            year_s_q <= year_s_d;
            mode_s_q <= mode_s_d;
            sec_r_q  <= sec_r_d;
            min_r_q  <= min_r_d;
            hour_r_q <= hour_r_d;
            day_r_q  <= day_r_d;
            mont_r_q <= mont_r_d;
            year_r_q <= year_r_d;
            buf_q    <= buf_d;
            dpb_q    <= dpb_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_dongho_display.sv
// ---------------------------------------------------------------------------
// tb_dongho_display
//
// Self-checking bench for dongho_display with SCAN_DIV = 8. Expected display
// contents come from a decimal model of the calendar fields (division and
// modulo by 10) and the segment table; each scenario task drives inputs and
// compares the multiplexed outputs against that model.
// ---------------------------------------------------------------------------
module tb_dongho_display;

    localparam int SCAN_DIV = 8;
    localparam int FRAME    = 8 * SCAN_DIV;
    localparam int NOBS     = 3 * FRAME;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hour;
    logic [4:0]  day;
    logic [3:0]  mont;
    logic [12:0] year;
    logic        mode;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: expected digit value (15 = blank) and DP-lit flag per digit
    int exp_dig[8];
    bit exp_dp[8];

    logic [7:0] obs_an[NOBS];
    logic [6:0] obs_seg[NOBS];
    logic       obs_dp[NOBS];

    dongho_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .sec  (sec),
        .min  (min),
        .hour (hour),
        .day  (day),
        .mont (mont),
        .year (year),
        .mode (mode),
        .an   (an),
        .seg  (seg),
        .dp   (dp),
        .busy (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_code(input int v);
        case (v)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Decimal view of the fields as they should appear on the display.
    function automatic void set_model(input int s, input int m, input int h,
                                      input int d, input int mo, input int y,
                                      input bit md);
        for (int i = 0; i < 8; i++) exp_dp[i] = 1'b0;
        if (!md) begin
            exp_dig[7] = 15;       exp_dig[6] = 15;
            exp_dig[5] = h / 10;   exp_dig[4] = h % 10;
            exp_dig[3] = m / 10;   exp_dig[2] = m % 10;
            exp_dig[1] = s / 10;   exp_dig[0] = s % 10;
            exp_dp[4] = 1'b1;      exp_dp[2] = 1'b1;
        end else begin
            exp_dig[7] = d / 10;   exp_dig[6] = d % 10;
            exp_dig[5] = mo / 10;  exp_dig[4] = mo % 10;
            exp_dig[3] = y / 1000; exp_dig[2] = (y / 100) % 10;
            exp_dig[1] = (y / 10) % 10;
            exp_dig[0] = y % 10;
            exp_dp[6] = 1'b1;      exp_dp[4] = 1'b1;
        end
    endfunction

    // Expected {seg, dp} for whichever digit a given enable pattern selects.
    function automatic logic [7:0] expect_sd(input logic [7:0] an_v);
        logic [7:0] m;
        expect_sd = 8'hFF;
        for (int d = 0; d < 8; d++) begin
            m = ~(8'h01 << d);
            if (an_v === m) expect_sd = {seg_code(exp_dig[d]), ~exp_dp[d]};
        end
    endfunction

    task automatic drive(input int s, input int m, input int h, input int d,
                         input int mo, input int y, input bit md);
        sec  = 6'(s);
        min  = 6'(m);
        hour = 5'(h);
        day  = 5'(d);
        mont = 4'(mo);
        year = 13'(y);
        mode = md;
    endtask

    // Waits for the next snapshot and its conversion; returns how many
    // sampled cycles busy was high. Leaves time at the first negedge where
    // the committed buffer has reached the outputs.
    task automatic convert(output int busy_len, output bit timeout);
        int n;
        timeout  = 1'b0;
        busy_len = 0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) timeout = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) timeout = 1'b1;
        while (busy === 1'b1 && busy_len < 200) begin
            busy_len++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            obs_an[i]  = an;
            obs_seg[i] = seg;
            obs_dp[i]  = dp;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        tests_run++;
        if (an !== 8'hFF) begin
            tests_failed++;
            $display("[TB] FAIL reset_an: got %h, expected ff", an);
        end
        tests_run++;
        if (seg !== 7'h7F || dp !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_seg_dp: got seg=%b dp=%b, expected 1111111/1", seg, dp);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %b, expected 0", busy);
        end

        drive(56, 34, 12, 1, 1, 2000, 1'b0);
        rst = 1'b0;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 200) begin
            tests_run++;
            if (seg !== 7'h7F || dp !== 1'b1 || $countones(~an) != 1) begin
                tests_failed++;
                $display("[TB] FAIL reset_blank cycle %0d: an=%b seg=%b dp=%b, expected one-hot an, seg 1111111, dp 1", n, an, seg, dp);
            end
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (n != 46) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy_len: got %0d cycles, expected 46", n);
        end
        @(negedge clk);
        set_model(56, 34, 12, 1, 1, 2000, 1'b0);
        collect(FRAME);
        for (int i = 0; i < FRAME; i++) begin
            tests_run++;
            if ($countones(~obs_an[i]) != 1 || {obs_seg[i], obs_dp[i]} !== expect_sd(obs_an[i])) begin
                tests_failed++;
                $display("[TB] FAIL reset_first_frame cycle %0d: an=%b seg=%b dp=%b, expected seg/dp %b", i, obs_an[i], obs_seg[i], obs_dp[i], expect_sd(obs_an[i]));
            end
        end
    endtask

    task automatic test_time_view();
        int  len;
        bit  to;
        bit  seen;
        drive(59, 59, 23, 1, 1, 2000, 1'b0);
        convert(len, to);
        tests_run++;
        if (to || len != 46) begin
            tests_failed++;
            $display("[TB] FAIL time_busy_len: got %0d (timeout %0b), expected 46", len, to);
        end
        set_model(59, 59, 23, 1, 1, 2000, 1'b0);
        collect(FRAME);
        seen = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            tests_run++;
            if ($countones(~obs_an[i]) != 1 || {obs_seg[i], obs_dp[i]} !== expect_sd(obs_an[i])) begin
                tests_failed++;
                $display("[TB] FAIL time_view cycle %0d: an=%b seg=%b dp=%b, expected seg/dp %b", i, obs_an[i], obs_seg[i], obs_dp[i], expect_sd(obs_an[i]));
            end
            if (obs_an[i] === 8'b11111011 && !seen) begin
                seen = 1'b1;
                tests_run++;
                if (obs_seg[i] !== 7'b0010000 || obs_dp[i] !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL time_digit2: got seg=%b dp=%b, expected 0010000/0", obs_seg[i], obs_dp[i]);
                end
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL time_digit2_seen: got no an=11111011 in frame, expected one");
        end
    endtask

    task automatic test_date_view();
        int len;
        bit to;
        drive(0, 0, 0, 31, 12, 2099, 1'b1);
        convert(len, to);
        tests_run++;
        if (to || len != 46) begin
            tests_failed++;
            $display("[TB] FAIL date_busy_len: got %0d (timeout %0b), expected 46", len, to);
        end
        set_model(0, 0, 0, 31, 12, 2099, 1'b1);
        collect(FRAME);
        for (int i = 0; i < FRAME; i++) begin
            tests_run++;
            if ($countones(~obs_an[i]) != 1 || {obs_seg[i], obs_dp[i]} !== expect_sd(obs_an[i])) begin
                tests_failed++;
                $display("[TB] FAIL date_view cycle %0d: an=%b seg=%b dp=%b, expected seg/dp %b", i, obs_an[i], obs_seg[i], obs_dp[i], expect_sd(obs_an[i]));
            end
        end
    endtask

    task automatic test_extremes();
        int len;
        bit to;
        int s, m, h, d, mo, y;
        bit md;
        for (int v = 0; v < 4; v++) begin
            case (v)
                0:       begin s = 63; m = 0; h = 31; d = 0;  mo = 0;  y = 0;    md = 1'b0; end
                1:       begin s = 0;  m = 0; h = 0;  d = 0;  mo = 0;  y = 8191; md = 1'b1; end
                2:       begin s = 0;  m = 0; h = 0;  d = 0;  mo = 0;  y = 0;    md = 1'b0; end
                default: begin s = 0;  m = 0; h = 0;  d = 31; mo = 15; y = 0;    md = 1'b1; end
            endcase
            drive(s, m, h, d, mo, y, md);
            convert(len, to);
            tests_run++;
            if (to || len != 46) begin
                tests_failed++;
                $display("[TB] FAIL extremes_busy_len vec %0d: got %0d (timeout %0b), expected 46", v, len, to);
            end
            set_model(s, m, h, d, mo, y, md);
            collect(FRAME);
            for (int i = 0; i < FRAME; i++) begin
                tests_run++;
                if ($countones(~obs_an[i]) != 1 || {obs_seg[i], obs_dp[i]} !== expect_sd(obs_an[i])) begin
                    tests_failed++;
                    $display("[TB] FAIL extremes vec %0d cycle %0d: an=%b seg=%b dp=%b, expected seg/dp %b", v, i, obs_an[i], obs_seg[i], obs_dp[i], expect_sd(obs_an[i]));
                end
            end
        end
    endtask

    task automatic test_random();
        int len;
        bit to;
        int s, m, h, d, mo, y;
        bit md;
        for (int v = 0; v < 6; v++) begin
            s  = int'($urandom_range(0, 63));
            m  = int'($urandom_range(0, 63));
            h  = int'($urandom_range(0, 31));
            d  = int'($urandom_range(0, 31));
            mo = int'($urandom_range(0, 15));
            y  = int'($urandom_range(0, 8191));
            md = 1'($urandom_range(0, 1));
            drive(s, m, h, d, mo, y, md);
            convert(len, to);
            tests_run++;
            if (to || len != 46) begin
                tests_failed++;
                $display("[TB] FAIL random_busy_len vec %0d: got %0d (timeout %0b), expected 46", v, len, to);
            end
            set_model(s, m, h, d, mo, y, md);
            collect(FRAME);
            for (int i = 0; i < FRAME; i++) begin
                tests_run++;
                if ($countones(~obs_an[i]) != 1 || {obs_seg[i], obs_dp[i]} !== expect_sd(obs_an[i])) begin
                    tests_failed++;
                    $display("[TB] FAIL random vec %0d cycle %0d: an=%b seg=%b dp=%b, expected seg/dp %b", v, i, obs_an[i], obs_seg[i], obs_dp[i], expect_sd(obs_an[i]));
                end
            end
        end
    endtask

    task automatic test_coherency();
        int len;
        bit to;
        int n;
        bit phase;
        drive(10, 20, 8, 15, 6, 2024, 1'b0);
        convert(len, to);
        tests_run++;
        if (to || len != 46) begin
            tests_failed++;
            $display("[TB] FAIL coherency_busy_len: got %0d (timeout %0b), expected 46", len, to);
        end
        set_model(10, 20, 8, 15, 6, 2024, 1'b0);
        repeat (10) @(negedge clk);

        // Mid-frame change; old contents must hold until the next commit.
        drive(33, 20, 8, 15, 6, 2024, 1'b1);
        n = 0;
        phase = 1'b0;
        while (n < 300) begin
            tests_run++;
            if ($countones(~an) != 1 || {seg, dp} !== expect_sd(an)) begin
                tests_failed++;
                $display("[TB] FAIL coherency_hold cycle %0d: an=%b seg=%b dp=%b, expected seg/dp %b", n, an, seg, dp, expect_sd(an));
            end
            if (!phase && busy === 1'b1) begin
                phase = 1'b1;
                sec  = 6'd44;
                mode = 1'b0;
            end else if (phase && busy !== 1'b1) begin
                break;
            end
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (!phase || n >= 300) begin
            tests_failed++;
            $display("[TB] FAIL coherency_snapshot: got phase=%0b after %0d cycles, expected a completed conversion", phase, n);
        end
        @(negedge clk);
        set_model(33, 20, 8, 15, 6, 2024, 1'b1);
        collect(FRAME);
        for (int i = 0; i < FRAME; i++) begin
            tests_run++;
            if ($countones(~obs_an[i]) != 1 || {obs_seg[i], obs_dp[i]} !== expect_sd(obs_an[i])) begin
                tests_failed++;
                $display("[TB] FAIL coherency_new cycle %0d: an=%b seg=%b dp=%b, expected seg/dp %b", i, obs_an[i], obs_seg[i], obs_dp[i], expect_sd(obs_an[i]));
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        drive(5, 6, 7, 8, 9, 1999, 1'b1);
        n = 0;
        while (busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
        while (busy !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_async: got an=%h seg=%b dp=%b busy=%b, expected ff/1111111/1/0", an, seg, dp, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 200) begin
            tests_run++;
            if (seg !== 7'h7F || dp !== 1'b1 || $countones(~an) != 1) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid_blank cycle %0d: an=%b seg=%b dp=%b, expected one-hot an, seg 1111111, dp 1", n, an, seg, dp);
            end
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (n != 46) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_busy_len: got %0d cycles, expected 46", n);
        end
        @(negedge clk);
        set_model(5, 6, 7, 8, 9, 1999, 1'b1);
        collect(FRAME);
        for (int i = 0; i < FRAME; i++) begin
            tests_run++;
            if ($countones(~obs_an[i]) != 1 || {obs_seg[i], obs_dp[i]} !== expect_sd(obs_an[i])) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid_frame cycle %0d: an=%b seg=%b dp=%b, expected seg/dp %b", i, obs_an[i], obs_seg[i], obs_dp[i], expect_sd(obs_an[i]));
            end
        end
    endtask

    task automatic test_scan();
        int p;
        int d0;
        bit ok;
        logic [7:0] m;
        collect(2 * FRAME + 2 * SCAN_DIV);
        p = -1;
        for (int i = 1; i <= SCAN_DIV; i++) begin
            if (p < 0 && obs_an[i] !== obs_an[i-1]) p = i;
        end
        tests_run++;
        if (p < 0) begin
            tests_failed++;
            $display("[TB] FAIL scan_change: got no an change within %0d cycles, expected one", SCAN_DIV + 1);
        end else begin
            d0 = 0;
            for (int d = 0; d < 8; d++) begin
                m = ~(8'h01 << d);
                if (obs_an[p] === m) d0 = d;
            end
            for (int k = 0; k < 16; k++) begin
                m = ~(8'h01 << ((d0 + k) % 8));
                ok = 1'b1;
                for (int j = 0; j < SCAN_DIV; j++) begin
                    if (obs_an[p + k * SCAN_DIV + j] !== m) ok = 1'b0;
                end
                tests_run++;
                if (!ok) begin
                    tests_failed++;
                    $display("[TB] FAIL scan_run %0d: got an=%b at run start, expected %b held %0d cycles", k, obs_an[p + k * SCAN_DIV], m, SCAN_DIV);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_time_view();
        test_date_view();
        test_extremes();
        test_random();
        test_coherency();
        test_reset_mid();
        test_scan();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
